// File: rtl/mem_init_pkg.sv
// Shared types and default widths for the memory burst initiator.
package mem_init_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_LEN_WIDTH  = 4;
endpackage

// File: rtl/mem_burst_initiator.sv
// Burst initiator for a single-port memory: accepts write/read burst commands,
// issues one beat per cycle and returns read data as an unbackpressured stream.
module mem_burst_initiator
  import mem_init_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  cmd_done,
  output logic                  err_missing,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_valid_out
);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_cnt_q;
  logic [LEN_WIDTH-1:0]  beat_cnt_q;
  logic                  cmd_ready_q, wdata_ready_q;
  logic                  rd_last_q, pend_q, pend_last_q;
  logic                  rdata_valid_q, rdata_last_q, cmd_done_q, err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  mem_write_en_q, mem_read_en_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0] mem_data_in_q;

  logic wbeat_d, last_beat_d;
  assign wbeat_d     = (state_q == WRITE) && wdata_valid && wdata_ready_q;
  assign last_beat_d = (beat_cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      addr_cnt_q     <= '0;
      beat_cnt_q     <= '0;
      cmd_ready_q    <= 1'b0;
      wdata_ready_q  <= 1'b0;
      rd_last_q      <= 1'b0;
      pend_q         <= 1'b0;
      pend_last_q    <= 1'b0;
      rdata_valid_q  <= 1'b0;
      rdata_last_q   <= 1'b0;
      rdata_q        <= '0;
      cmd_done_q     <= 1'b0;
      err_q          <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_read_en_q  <= 1'b0;
      mem_address_q  <= '0;
      mem_data_in_q  <= '0;
    end else begin
      mem_write_en_q <= 1'b0;
      mem_read_en_q  <= 1'b0;
      rd_last_q      <= 1'b0;
      rdata_valid_q  <= 1'b0;
      rdata_last_q   <= 1'b0;
      cmd_done_q     <= 1'b0;

      // Response stage: each issued read is expected back one cycle later.
      // A missing response still retires the beat so the burst can finish.
      pend_q      <= mem_read_en_q;
      pend_last_q <= rd_last_q;
      if (pend_q) begin
        if (mem_valid_out) begin
          rdata_valid_q <= 1'b1;
          rdata_q       <= mem_data_out;
          rdata_last_q  <= pend_last_q;
        end else begin
          err_q <= 1'b1;
        end
        cmd_done_q <= pend_last_q;
      end

      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_cnt_q  <= cmd_addr;
            beat_cnt_q  <= cmd_len;
            if (cmd_write) begin
              state_q       <= WRITE;
              wdata_ready_q <= 1'b1;
            end else begin
              state_q <= READ;
            end
          end
        end
        WRITE: begin
          if (wbeat_d) begin
            mem_write_en_q <= 1'b1;
            mem_address_q  <= addr_cnt_q;
            mem_data_in_q  <= wdata;
            addr_cnt_q     <= addr_cnt_q + ADDR_WIDTH'(1);
            beat_cnt_q     <= beat_cnt_q - LEN_WIDTH'(1);
            if (last_beat_d) begin
              state_q       <= IDLE;
              cmd_done_q    <= 1'b1;
              cmd_ready_q   <= 1'b1;
              wdata_ready_q <= 1'b0;
            end
          end
        end
        READ: begin
          mem_read_en_q <= 1'b1;
          mem_address_q <= addr_cnt_q;
          rd_last_q     <= last_beat_d;
          addr_cnt_q    <= addr_cnt_q + ADDR_WIDTH'(1);
          beat_cnt_q    <= beat_cnt_q - LEN_WIDTH'(1);
          if (last_beat_d) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!pend_q && !mem_read_en_q) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign wdata_ready  = wdata_ready_q;
  assign rdata_valid  = rdata_valid_q;
  assign rdata        = rdata_q;
  assign rdata_last   = rdata_last_q;
  assign cmd_done     = cmd_done_q;
  assign err_missing  = err_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_read_en  = mem_read_en_q;
  assign mem_address  = mem_address_q;
  assign mem_data_in  = mem_data_in_q;

endmodule
